// File: rtl/fifo_pkg.sv
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared helpers for the asynchronous FIFO pointer controllers.
//                Provides the depth derivation, the default almost-full rule
//                and binary/Gray conversions.
//                The conversions work on 32-bit values. Callers zero-extend
//                their pointer, then cast the result back to the pointer
//                width. A zero-extended Gray code converts to a
//                zero-extended binary value, so truncation is exact.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    localparam int unsigned C_FN_WIDTH = 32;

    // Number of FIFO entries for a given address width.
    function automatic int unsigned fifo_depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    // Default almost-full threshold: two entries short of full.
    function automatic int unsigned afull_default(input int unsigned addr_width);
        return (32'd1 << addr_width) - 32'd2;
    endfunction

    function automatic logic [C_FN_WIDTH-1:0] bin2gray(input logic [C_FN_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [C_FN_WIDTH-1:0] gray2bin(input logic [C_FN_WIDTH-1:0] gray);
        logic [C_FN_WIDTH-1:0] bin;
        bin[C_FN_WIDTH-1] = gray[C_FN_WIDTH-1];
        for (int i = C_FN_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_wptr_ctrl_if.sv
// ============================================================================
//  Module      : fifo_wptr_ctrl_if
//  Description : Write-side pointer bus of the asynchronous FIFO.
//                master : the write pointer controller (drives pointers and
//                         flags, receives the request and the read pointer)
//                slave  : the write client / read side / memory
//                W_Ovf exists only when W_FIFO_OVF_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fifo_wptr_ctrl_if #(
    parameter int ADDR_WIDTH = 4
) ();
    logic                  W_inc;
    logic [ADDR_WIDTH:0]   R_ptr;
    logic [ADDR_WIDTH:0]   W_ptr;
    logic [ADDR_WIDTH-1:0] W_Addr;
    logic                  W_en;
    logic                  W_Full;
    logic                  W_Afull;
    logic [ADDR_WIDTH:0]   W_Level;
`ifdef W_FIFO_OVF_EN
    logic                  W_Ovf;
`endif

    modport master (
        input  W_inc, R_ptr,
        output W_ptr, W_Addr, W_en, W_Full, W_Afull, W_Level
`ifdef W_FIFO_OVF_EN
        , output W_Ovf
`endif
    );

    modport slave (
        output W_inc, R_ptr,
        input  W_ptr, W_Addr, W_en, W_Full, W_Afull, W_Level
`ifdef W_FIFO_OVF_EN
        , input W_Ovf
`endif
    );
endinterface

`default_nettype wire

// File: rtl/cdc_ptr_sync.sv
// ============================================================================
//  Module      : cdc_ptr_sync
//  Description : Multi-flop synchroniser for a Gray-coded pointer.
//                Ports: clk, rst (sync, active-high), i_d (foreign-domain
//                pointer), o_q (synchronised pointer, STAGES cycles late).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdc_ptr_sync #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 5
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output wire logic [WIDTH-1:0] o_q
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("cdc_ptr_sync: STAGES must be at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_chain_q [STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_chain_q[i] <= '0;
            end
        end else begin
            r_chain_q[0] <= i_d;
            for (int i = 1; i < STAGES; i++) begin
                r_chain_q[i] <= r_chain_q[i-1];
            end
        end
    end

    assign o_q = r_chain_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fifo_wptr_ctrl.sv
// ============================================================================
//  Module      : fifo_wptr_ctrl
//  Description : Write-side pointer controller of the asynchronous FIFO.
//                Keeps the binary write pointer and the Gray write pointer.
//                Produces registered full, almost-full and fill level
//                against the synchronised read pointer. Writes attempted
//                while full are dropped.
//                Ports: W_CLK, W_rst (sync, active-high), bus (master
//                modport: W_inc, R_ptr in; W_ptr, W_Addr, W_en, W_Full,
//                W_Afull, W_Level [, W_Ovf] out).
//                Optional macro W_FIFO_OVF_EN adds the sticky W_Ovf flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LEVEL = int'(afull_default(ADDR_WIDTH))
) (
    input  wire logic          W_CLK,
    input  wire logic          W_rst,
    fifo_wptr_ctrl_if.master   bus
);

    localparam int C_PW    = ADDR_WIDTH + 1;
    localparam int C_DEPTH = int'(fifo_depth(ADDR_WIDTH));

    generate
        if (ADDR_WIDTH < 2) begin : g_bad_addr_width
            $error("fifo_wptr_ctrl: ADDR_WIDTH must be at least 2");
        end
        if (AFULL_LEVEL < 1 || AFULL_LEVEL > C_DEPTH) begin : g_bad_afull
            $error("fifo_wptr_ctrl: AFULL_LEVEL must be in 1..DEPTH");
        end
    endgenerate

    // Read pointer brought into the write domain.
    logic [C_PW-1:0] w_wq_rptr;
    logic [C_PW-1:0] w_rbin;

    cdc_ptr_sync #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (C_PW)
    ) u_rptr_sync (
        .clk (W_CLK),
        .rst (W_rst),
        .i_d (bus.R_ptr),
        .o_q (w_wq_rptr)
    );

    assign w_rbin = C_PW'(gray2bin(C_FN_WIDTH'(w_wq_rptr)));

    logic [C_PW-1:0] r_wbin_q,  w_wbin_d;
    logic [C_PW-1:0] r_gray_q,  w_gray_d;
    logic [C_PW-1:0] r_level_q, w_level_d;
    logic            r_full_q,  w_full_d;
    logic            r_afull_q, w_afull_d;
    logic            w_en;

    always_comb begin
        w_en      = bus.W_inc & ~r_full_q;
        w_wbin_d  = r_wbin_q + C_PW'(w_en);
        w_gray_d  = C_PW'(bin2gray(C_FN_WIDTH'(w_wbin_d)));
        // Full when the write pointer is exactly one lap ahead of the read
        // pointer. In Gray code, a one-lap offset flips the two MSBs and
        // leaves the lower bits equal.
        w_full_d  = (w_gray_d == {~w_wq_rptr[C_PW-1:C_PW-2], w_wq_rptr[C_PW-3:0]});
        // Modulo subtraction stays correct across pointer wrap.
        w_level_d = w_wbin_d - w_rbin;
        w_afull_d = (C_FN_WIDTH'(w_level_d) >= C_FN_WIDTH'(AFULL_LEVEL));
    end

    always_ff @(posedge W_CLK) begin
        if (W_rst) begin
            r_wbin_q  <= '0;
            r_gray_q  <= '0;
            r_level_q <= '0;
            r_full_q  <= 1'b0;
            r_afull_q <= 1'b0;
        end else begin
            r_wbin_q  <= w_wbin_d;
            r_gray_q  <= w_gray_d;
            r_level_q <= w_level_d;
            r_full_q  <= w_full_d;
            r_afull_q <= w_afull_d;
        end
    end

`ifdef W_FIFO_OVF_EN
    logic r_ovf_q, w_ovf_d;

    always_comb begin
        w_ovf_d = r_ovf_q | (bus.W_inc & r_full_q);
    end

    always_ff @(posedge W_CLK) begin
        if (W_rst) begin
            r_ovf_q <= 1'b0;
        end else begin
            r_ovf_q <= w_ovf_d;
        end
    end

    assign bus.W_Ovf = r_ovf_q;
`endif

    assign bus.W_en    = w_en;
    assign bus.W_Addr  = r_wbin_q[ADDR_WIDTH-1:0];
    assign bus.W_ptr   = r_gray_q;
    assign bus.W_Full  = r_full_q;
    assign bus.W_Afull = r_afull_q;
    assign bus.W_Level = r_level_q;

endmodule

`default_nettype wire

// File: doc/fifo_wptr_ctrl.md
# fifo_wptr_ctrl

Parametrised write-side pointer controller for the asynchronous FIFO, generalising the existing write pointer block. Sits in the write clock domain: internally synchronises the incoming Gray read pointer and maintains binary write address, Gray write pointer, registered full, almost-full and fill level. Drops writes attempted while full and can optionally flag them as overflow. Pairs with the read-side controller and the dual-port FIFO memory.

## Interface
- ADDR_WIDTH, 4, memory address bits; DEPTH = 2^ADDR_WIDTH; minimum 2
- SYNC_STAGES, 2, flops in read-pointer synchroniser; minimum 2
- AFULL_LEVEL, DEPTH-2, fill level at or above which W_Afull asserts; range 1..DEPTH
- W_CLK  in  1  write-domain clock
- W_rst  in  1  synchronous, active-high reset
- W_inc  in  1  write request for this cycle
- R_ptr  in  ADDR_WIDTH+1  Gray read pointer, read-clock domain, unsynchronised
- W_ptr  out  ADDR_WIDTH+1  registered Gray write pointer, to read domain
- W_Addr  out  ADDR_WIDTH  binary memory write address, low bits of binary write pointer
- W_en  out  1  memory write enable = W_inc & !W_Full, combinational
- W_Full  out  1  registered full
- W_Afull  out  1  registered almost-full
- W_Level  out  ADDR_WIDTH+1  registered fill level, 0..DEPTH
- W_Ovf  out  1  sticky overflow flag, only with W_FIFO_OVF_EN

## Operation
- Synchroniser: R_ptr passes through SYNC_STAGES flops on W_CLK, giving wq_rptr (Gray); converted to binary rbin combinationally.
- Write accepted when W_en = 1. Binary pointer wbin_next = wbin + W_en, modulo 2^(ADDR_WIDTH+1).
- Gray: gray_next = (wbin_next >> 1) ^ wbin_next; W_ptr <= gray_next every cycle.
- Full: gray_next vs wq_rptr — two MSBs differ, remaining bits equal. W_Full <= that result.
- Level: lvl_next = (wbin_next - rbin) mod 2^(ADDR_WIDTH+1); W_Level <= lvl_next; never exceeds DEPTH.
- Almost-full: W_Afull <= (lvl_next >= AFULL_LEVEL).
- Write while W_Full = 1: dropped; pointer, address, level unchanged.
- Pointer wrap: wbin rolls from 2^(ADDR_WIDTH+1)-1 to 0; W_Addr wraps DEPTH-1 -> 0; full/level remain correct across wrap.
- Reset (any cycle, including mid-burst): on next W_CLK edge with W_rst = 1, wbin, W_ptr, synchroniser flops, W_Full, W_Afull, W_Level, W_Ovf all become 0. W_inc ignored during reset cycle.

## Timing
- Reset values: W_ptr 0, W_Addr 0, W_en follows W_inc (W_Full = 0), W_Full 0, W_Afull 0, W_Level 0, W_Ovf 0.
- W_Addr valid in same cycle as W_en; pointer advances on that edge.
- W_Full, W_Afull, W_Level reflect an accepted write on the same edge as the pointer advance (1 cycle after request).
- Read-side drain visible: SYNC_STAGES cycles to wq_rptr, +1 cycle to flags; full deassert latency SYNC_STAGES+1 W_CLK cycles after R_ptr stable. Flags pessimistic (full may persist), never optimistic.
- Back-to-back writes: one per cycle sustained until full.

## Configuration
- Macro W_FIFO_OVF_EN.
- Defined: W_Ovf port present; set on the edge following any cycle with W_inc = 1 and W_Full = 1; clears only on W_rst.
- Undefined: W_Ovf port and its flop absent; dropped writes silently ignored.

## Structure
- Shared package fifo_pkg: gray-to-binary and binary-to-gray functions, DEPTH derivation constant, default AFULL_LEVEL rule; used by read-side controller too.
- One sub-module: cdc_ptr_sync (SYNC_STAGES-deep, WIDTH-wide flop chain, synchronous active-high reset), reused by the read side.

## Test plan
- ADDR_WIDTH=4, SYNC_STAGES=2, AFULL_LEVEL=14, R_ptr=0: reset, then 16 consecutive writes -> W_Addr 0..15, W_Level 1..16, W_Afull rises after 14th write, W_Full rises after 16th, W_ptr = 5'b11000.
- While full, assert W_inc 3 cycles -> W_ptr, W_Addr, W_Level unchanged; W_Ovf = 1 (with macro), stays 1 until W_rst.
- From full, R_ptr steps to Gray 1 (5'b00001) -> W_Full falls exactly 3 cycles later, W_Level = 15.
- Write/read 40 words with R_ptr trailing by 4 -> wbin wraps past 31 to 0, W_Level stays 4, W_Full never asserts.
- Assert W_rst mid-burst at level 9 -> next edge all outputs 0, next write uses W_Addr 0.
- Compile without W_FIFO_OVF_EN -> W_Ovf absent, write-while-full behaviour otherwise identical.
